// File: rtl/pri_arbiter.sv
// Clocked N-way arbiter with fixed or round-robin priority and a per-owner hold limit.
// One owner at a time; all outputs come straight from registers.
module pri_arbiter #(
    parameter int N        = 8,
    parameter int AW       = 3,
    parameter int MAX_HOLD = 16,
    parameter int RR_EN    = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic [N-1:0]  req_vec,
    output logic [N-1:0]  gnt_vec,
    output logic [AW-1:0] gnt_addr,
    output logic          gnt_valid,
    output logic          timeout
);

    localparam int HCW = $clog2(MAX_HOLD) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t         r_state;
    logic [N-1:0]   r_gnt_vec;
    logic [AW-1:0]  r_gnt_addr;
    logic           r_timeout;
    logic [HCW-1:0] r_hold_cnt;
    logic [AW-1:0]  r_ptr;

    state_t         w_state_nxt;
    logic [N-1:0]   w_gnt_vec_nxt;
    logic [AW-1:0]  w_gnt_addr_nxt;
    logic           w_timeout_nxt;
    logic [HCW-1:0] w_hold_cnt_nxt;
    logic [AW-1:0]  w_ptr_nxt;

    logic [AW-1:0]  w_base;
    logic           w_win_found;
    logic [AW-1:0]  w_win_addr;
    logic           w_owner_req;
    logic           w_hold_last;

    // Search downward from base-1, wrapping, so base itself is tried last.
    // Fixed priority is the same search anchored at 0: N-1 first, 0 last.
    always_comb begin
        w_base      = (RR_EN != 0) ? r_ptr : '0;
        w_win_found = 1'b0;
        w_win_addr  = '0;
        for (int i = 1; i <= N; i++) begin
            logic [AW-1:0] idx;
            idx = w_base - AW'(i);
            if (!w_win_found && req_vec[idx]) begin
                w_win_found = 1'b1;
                w_win_addr  = idx;
            end
        end
    end

    assign w_owner_req = req_vec[r_gnt_addr];
    assign w_hold_last = (MAX_HOLD != 0) && (r_hold_cnt == HCW'(MAX_HOLD - 1));

    // NOTE: every signal written here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_vec_nxt  = r_gnt_vec;
        w_gnt_addr_nxt = r_gnt_addr;
        w_timeout_nxt  = 1'b0;
        w_hold_cnt_nxt = r_hold_cnt;
        w_ptr_nxt      = r_ptr;
        case (r_state)
            IDLE: begin
                w_gnt_vec_nxt  = '0;
                w_gnt_addr_nxt = '0;
                if (ena && w_win_found) begin
                    w_state_nxt    = BUSY;
                    w_gnt_vec_nxt  = {{(N-1){1'b0}}, 1'b1} << w_win_addr;
                    w_gnt_addr_nxt = w_win_addr;
                    w_hold_cnt_nxt = '0;
                end
            end
            BUSY: begin
                if (!w_owner_req || w_hold_last) begin
                    // A dropped request takes precedence, so timeout only fires
                    // when the owner is still asking.
                    w_state_nxt    = IDLE;
                    w_gnt_vec_nxt  = '0;
                    w_gnt_addr_nxt = '0;
                    w_hold_cnt_nxt = '0;
                    w_timeout_nxt  = w_owner_req;
                    if (RR_EN != 0) begin
                        w_ptr_nxt = r_gnt_addr;
                    end
                end else if (MAX_HOLD != 0) begin
                    w_hold_cnt_nxt = r_hold_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_gnt_vec  <= '0;
            r_gnt_addr <= '0;
            r_timeout  <= 1'b0;
            r_hold_cnt <= '0;
            r_ptr      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt_vec  <= w_gnt_vec_nxt;
            r_gnt_addr <= w_gnt_addr_nxt;
            r_timeout  <= w_timeout_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_ptr      <= w_ptr_nxt;
        end
    end

    assign gnt_vec   = r_gnt_vec;
    assign gnt_addr  = r_gnt_addr;
    assign gnt_valid = |r_gnt_vec;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_pri_arbiter.sv
// Bench for pri_arbiter: a round-robin instance (MAX_HOLD=16) and a fixed-priority
// instance (MAX_HOLD=4) share stimulus and are checked against a behavioural model.
module tb_pri_arbiter;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [7:0] req;

    logic [7:0] rr_gnt_vec,   fx_gnt_vec;
    logic [2:0] rr_gnt_addr,  fx_gnt_addr;
    logic       rr_gnt_valid, fx_gnt_valid;
    logic       rr_timeout,   fx_timeout;

    pri_arbiter #(.N(8), .AW(3), .MAX_HOLD(16), .RR_EN(1)) u_dut (
        .clk(clk), .rst(rst), .ena(ena), .req_vec(req),
        .gnt_vec(rr_gnt_vec), .gnt_addr(rr_gnt_addr),
        .gnt_valid(rr_gnt_valid), .timeout(rr_timeout)
    );

    pri_arbiter #(.N(8), .AW(3), .MAX_HOLD(4), .RR_EN(0)) u_fix (
        .clk(clk), .rst(rst), .ena(ena), .req_vec(req),
        .gnt_vec(fx_gnt_vec), .gnt_addr(fx_gnt_addr),
        .gnt_valid(fx_gnt_valid), .timeout(fx_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model, index 0 = round-robin instance, 1 = fixed instance.
    // m_cnt counts grant cycles already shown for the current owner.
    int m_owner [2];
    int m_cnt   [2];
    int m_ptr   [2];
    bit m_to    [2];

    function automatic int mh_of(input int m);
        return (m == 0) ? 16 : 4;
    endfunction

    function automatic int pick(input int m, input logic [7:0] r);
        if (m == 0) begin
            for (int k = 1; k <= 8; k++) begin
                int c;
                c = (m_ptr[m] - k + 8) % 8;
                if (r[c]) return c;
            end
        end else begin
            for (int c = 7; c >= 0; c--) if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_update();
        for (int m = 0; m < 2; m++) begin
            m_to[m] = 1'b0;
            if (rst) begin
                m_owner[m] = -1;
                m_cnt[m]   = 0;
                m_ptr[m]   = 0;
            end else if (m_owner[m] >= 0) begin
                if (!req[m_owner[m]] || m_cnt[m] == mh_of(m)) begin
                    m_to[m] = req[m_owner[m]];
                    if (m == 0) m_ptr[m] = m_owner[m];
                    m_owner[m] = -1;
                    m_cnt[m]   = 0;
                end else begin
                    m_cnt[m]++;
                end
            end else if (ena && req != 8'h00) begin
                m_owner[m] = pick(m, req);
                m_cnt[m]   = 1;
            end
        end
    endtask

    task automatic check_outputs();
        logic [7:0] exp_vec;
        exp_vec = (m_owner[0] >= 0) ? (8'h01 << m_owner[0]) : 8'h00;
        check("rr.gnt_vec", rr_gnt_vec, exp_vec);
        check("rr.gnt_valid", rr_gnt_valid, m_owner[0] >= 0);
        check("rr.timeout", rr_timeout, m_to[0]);
        if (m_owner[0] >= 0) check("rr.gnt_addr", rr_gnt_addr, m_owner[0]);
        exp_vec = (m_owner[1] >= 0) ? (8'h01 << m_owner[1]) : 8'h00;
        check("fx.gnt_vec", fx_gnt_vec, exp_vec);
        check("fx.gnt_valid", fx_gnt_valid, m_owner[1] >= 0);
        check("fx.timeout", fx_timeout, m_to[1]);
        if (m_owner[1] >= 0) check("fx.gnt_addr", fx_gnt_addr, m_owner[1]);
    endtask

    // Inputs change 1 time unit after the edge; outputs are checked at the same point.
    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    int         exp_order [9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    int         got_order [$];
    logic       prev_valid;
    int         run_len;
    int         first_run;
    int         n_to;
    int         n_regrant;

    initial begin
        rst = 1'b1;
        ena = 1'b0;
        req = 8'h00;
        #1;

        // Reset, then idle with no requests.
        do_reset();
        ena = 1'b1;
        for (int i = 0; i < 4; i++) cycle();

        // Fixed instance: 8'h81, bit 7 dropped after three grant cycles.
        do_reset();
        req = 8'h81;
        n_regrant = 0;
        prev_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cycle();
            if (fx_gnt_valid) check("s2.fx_addr", fx_gnt_addr, 7);
            if (fx_gnt_valid && !prev_valid) n_regrant++;
            prev_valid = fx_gnt_valid;
            req = 8'h81;
            if (m_owner[1] == 7 && m_cnt[1] == 3) req[7] = 1'b0;
        end
        check("s2.regrants", n_regrant >= 3, 1);

        // Round-robin instance: all request, each owner drops after two cycles.
        do_reset();
        req = 8'hFF;
        prev_valid = 1'b0;
        got_order.delete();
        for (int i = 0; i < 60 && got_order.size() < 9; i++) begin
            cycle();
            if (rr_gnt_valid && !prev_valid) got_order.push_back(int'(rr_gnt_addr));
            prev_valid = rr_gnt_valid;
            req = 8'hFF;
            if (m_owner[0] >= 0 && m_cnt[0] == 2) req[m_owner[0]] = 1'b0;
        end
        check("s3.n_grants", got_order.size(), 9);
        for (int i = 0; i < got_order.size() && i < 9; i++)
            check("s3.order", got_order[i], exp_order[i]);

        // Hold limit: 8'h04 held forever.
        do_reset();
        req = 8'h04;
        run_len = 0;
        first_run = -1;
        n_to = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (rr_gnt_vec == 8'h04) run_len++;
            else if (run_len != 0) begin
                if (first_run < 0) first_run = run_len;
                run_len = 0;
            end
            if (rr_timeout) begin
                n_to++;
                check("s4.to_while_idle", rr_gnt_valid, 0);
            end
        end
        check("s4.hold_cycles", first_run, 16);
        check("s4.timeouts", n_to, 2);

        // Enable gating: no grant while ena=0; ena=0 mid-grant keeps the grant.
        do_reset();
        ena = 1'b0;
        req = 8'h10;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("s5.blocked", rr_gnt_valid, 0);
        end
        ena = 1'b1;
        cycle();
        check("s5.addr", rr_gnt_addr, 4);
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("s5.held", rr_gnt_vec, 8'h10);
        end
        req = 8'h00;
        cycle();
        cycle();
        ena = 1'b1;

        // Reset during a grant, then fixed-order behaviour resumes.
        do_reset();
        req = 8'h20;
        cycle();
        cycle();
        check("s6.owner5", rr_gnt_addr, 5);
        rst = 1'b1;
        cycle();
        check("s6.rst_vec", rr_gnt_vec, 8'h00);
        rst = 1'b0;
        req = 8'h60;
        cycle();
        check("s6.addr6", rr_gnt_addr, 6);

        // Random traffic with occasional enable drops and resets.
        for (int i = 0; i < 400; i++) begin
            req = 8'($urandom);
            if ($urandom_range(0, 3) == 0) req = req & 8'($urandom);
            ena = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 63) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
